// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts
// out one command byte (odd parity) on device clock edges and checks the device ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iSend,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQUEST = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    clk_s_q;
    logic [1:0]    dat_s_q;
    logic [2:0]    state_q, state_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    bcnt_q, bcnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic clk_sync, dat_sync, fall;
    assign clk_sync = clk_s_q[1];
    assign dat_sync = dat_s_q[1];
    assign fall     = clk_s_q[2] & ~clk_s_q[1];

    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        tcnt_d   = tcnt_q;
        bcnt_d   = bcnt_q;
        data_d   = data_q;
        par_d    = par_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (iSend) begin
                    data_d   = iData;
                    par_d    = ~^iData;
                    icnt_d   = '0;
                    clk_oe_d = 1'b1;
                    // a one-cycle inhibit is also its own last cycle
                    dat_oe_d = (INHIBIT_CYCLES == 1);
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                icnt_d = icnt_q + IW'(1);
                if (icnt_q == INH_START) dat_oe_d = 1'b1;
                if (icnt_q == INH_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    state_d  = S_REQUEST;
                end
            end
            S_REQUEST: begin
                tcnt_d  = TW'(1);
                bcnt_d  = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall) begin
                    bcnt_d = bcnt_q + 4'd1;
                    if (bcnt_q < 4'd8) begin
                        dat_oe_d = ~data_q[bcnt_q[2:0]];
                    end else if (bcnt_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (dat_sync) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: begin
                if (clk_sync && dat_sync) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // timeout wins over a coincident ack so oDone and oError stay exclusive
        if (state_q == S_SHIFT || state_q == S_ACK || state_q == S_RELEASE) begin
            tcnt_d = tcnt_q + TW'(1);
            if (tcnt_q == TMO_LAST) begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                done_d   = 1'b0;
                err_d    = 1'b1;
                state_d  = S_IDLE;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_s_q  <= 3'b111;
            dat_s_q  <= 2'b11;
            state_q  <= S_IDLE;
            icnt_q   <= '0;
            tcnt_q   <= '0;
            bcnt_q   <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            clk_s_q  <= {clk_s_q[1:0], PS2_CLK};
            dat_s_q  <= {dat_s_q[0], PS2_DATA};
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            tcnt_q   <= tcnt_d;
            bcnt_q   <= bcnt_d;
            data_q   <= data_d;
            par_q    <= par_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign oPS2_CLK_OE  = clk_oe_q;
    assign oPS2_DATA_OE = dat_oe_q;
    assign oBusy        = (state_q != S_IDLE);
    assign oDone        = done_q;
    assign oError       = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host while a
// scoreboard monitor checks every oDone/oError pulse against queued expectations.
module tb_ps2_host_tx;
    localparam int INH  = 5000;
    localparam int TMO  = 2000;
    localparam int H    = 20;
    localparam int WLIM = 20000;

    typedef struct packed {
        logic        done;
        logic        err;
        logic        chk_bits;
        logic [10:0] bits;
        logic        chk_tmo;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iData = 8'h00;
    logic       iSend = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       PS2_CLK, PS2_DATA;
    logic       oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError;

    exp_t        q[$];
    logic [10:0] obs_bits = '0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          req_cyc = 0;

    // open-drain bus: either side can pull a line low
    assign PS2_CLK  = dev_clk & ~oPS2_CLK_OE;
    assign PS2_DATA = dev_dat & ~oPS2_DATA_OE;

    always #5 Clock = ~Clock;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iSend(iSend),
        .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .oPS2_CLK_OE(oPS2_CLK_OE), .oPS2_DATA_OE(oPS2_DATA_OE),
        .oBusy(oBusy), .oDone(oDone), .oError(oError)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic d, input logic e, input logic cb, input logic [10:0] b,
                        input logic ct);
        exp_t x;
        x.done = d; x.err = e; x.chk_bits = cb; x.bits = b; x.chk_tmo = ct;
        q.push_back(x);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge Clock);
        iData = d;
        iSend = 1'b1;
        @(negedge Clock);
        iSend = 1'b0;
        chk("busy_after_send", {oBusy, oPS2_CLK_OE}, 2'b11);
    endtask

    // device side: start bit is seen as the host releases the clock, then one bit per rising edge
    task automatic dev_frame(input int nclk, input bit ack);
        int t;
        obs_bits = '0;
        t = 0;
        while (!oPS2_CLK_OE && t < WLIM) begin @(negedge Clock); t++; end
        chk("dev_wait_inhibit", t < WLIM, 1);
        t = 0;
        while (oPS2_CLK_OE && t < WLIM) begin @(negedge Clock); t++; end
        chk("dev_wait_release", t < WLIM, 1);
        obs_bits[0] = PS2_DATA;
        repeat (H) @(negedge Clock);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            repeat (H) @(negedge Clock);
            if (k <= 10) obs_bits[k] = PS2_DATA;
            dev_clk = 1'b1;
            repeat (H) @(negedge Clock);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || oBusy) && t < WLIM) begin @(negedge Clock); t++; end
        chk("frame_complete", t < WLIM, 1);
        repeat (10) @(negedge Clock);
    endtask

    // monitor: inhibit shape, timeout distance and every completion pulse
    initial begin
        int   inh_len;
        logic prev_clk_oe, prev_dat, prev2_dat;
        exp_t e;
        inh_len = 0; prev_clk_oe = 0; prev_dat = 0; prev2_dat = 0;
        forever begin
            @(negedge Clock);
            cyc++;
            if (Reset) begin
                inh_len = 0; prev_clk_oe = 0; prev_dat = 0; prev2_dat = 0;
            end else begin
                if (oPS2_CLK_OE) begin
                    inh_len++;
                end else if (prev_clk_oe) begin
                    chk("inhibit_len", inh_len, INH);
                    chk("start_bit_last_inhibit", {prev2_dat, prev_dat}, 2'b01);
                    chk("request_data_oe", oPS2_DATA_OE, 1);
                    req_cyc = cyc;
                    inh_len = 0;
                end
                if (oDone || oError) begin
                    chk("done_error_exclusive", oDone & oError, 0);
                    chk("busy_low_on_pulse", oBusy, 0);
                    chk("lines_released_on_pulse", {oPS2_CLK_OE, oPS2_DATA_OE}, 0);
                    if (q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pulse: got done=%0b error=%0b expected none (cycle %0d)",
                                 oDone, oError, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("done", oDone, e.done);
                        chk("error", oError, e.err);
                        if (e.chk_bits) chk("frame_bits", obs_bits, e.bits);
                        if (e.chk_tmo) chk("timeout_distance", cyc - req_cyc, TMO);
                    end
                end
                prev2_dat   = prev_dat;
                prev_dat    = oPS2_DATA_OE;
                prev_clk_oe = oPS2_CLK_OE;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        repeat (3) @(negedge Clock);
        chk("reset_outputs", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy, oDone, oError}, 5'b0);
        // reset beats a coincident start strobe
        iData = 8'hED; iSend = 1'b1;
        @(negedge Clock);
        iSend = 1'b0;
        chk("reset_priority", {oBusy, oPS2_CLK_OE}, 2'b00);
        Reset = 1'b0;
        repeat (5) @(negedge Clock);

        // 8'hED: 0,1,0,1,1,0,1,1,1,1,1 on the wire (start..stop)
        push(1, 0, 1, 11'b1_1_1110_1101_0, 0);
        send(8'hED);
        dev_frame(11, 1);
        wait_drain();

        // 8'h01 -> parity 0
        push(1, 0, 1, 11'b1_0_0000_0001_0, 0);
        send(8'h01);
        dev_frame(11, 1);
        wait_drain();

        // 8'h00 -> parity 1
        push(1, 0, 1, 11'b1_1_0000_0000_0, 0);
        send(8'h00);
        dev_frame(11, 1);
        wait_drain();

        // device never clocks: error exactly TMO cycles after the request
        push(0, 1, 0, 11'b0, 1);
        send(8'h55);
        dev_frame(0, 0);
        wait_drain();

        // device leaves data high on the 11th edge
        push(0, 1, 1, 11'b1_1_1111_1111_0, 0);
        send(8'hFF);
        dev_frame(11, 0);
        wait_drain();

        // a second strobe mid-frame with other data is ignored
        push(1, 0, 1, 11'b1_1_1010_0101_0, 0);
        send(8'hA5);
        fork
            dev_frame(11, 1);
            begin
                int t;
                t = 0;
                while (!oPS2_CLK_OE && t < WLIM) begin @(negedge Clock); t++; end
                while (oPS2_CLK_OE && t < WLIM) begin @(negedge Clock); t++; end
                repeat (150) @(negedge Clock);
                iData = 8'h3C; iSend = 1'b1;
                @(negedge Clock);
                iSend = 1'b0;
                chk("busy_during_ignored_send", oBusy, 1);
            end
        join
        wait_drain();

        // reset after the 5th falling edge: lines drop next cycle, no completion pulse
        send(8'h77);
        dev_frame(5, 1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("midframe_reset_release", {oPS2_CLK_OE, oPS2_DATA_OE, oBusy}, 3'b000);
        Reset = 1'b0;
        repeat (50) @(negedge Clock);

        // normal frame after the abort
        push(1, 0, 1, 11'b1_1_0101_1010_0, 0);
        send(8'h5A);
        dev_frame(11, 1);
        wait_drain();

        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
